// File: rtl/logic_unit_arbiter_pkg.sv
// rtl/logic_unit_arbiter_pkg.sv - shared opcodes and FSM state type for the logic unit arbiter
package logic_unit_arbiter_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_op_core.sv
// rtl/logic_unit_arbiter_op_core.sv - combinational bitwise logic core
module logic_op_core
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  // Decode the opcode; the reserved code yields zero and flags an error
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: begin
        y   = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin sharing of one logic core between two requesters
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  logic             grant_id;
  logic             any_valid;
  logic [WIDTH-1:0] core_y;
  logic             core_err;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (core_y),
    .err (core_err)
  );

  // Grant: a lone requester wins; under contention the one not served last wins
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_q;
    else                          grant_id = req1_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
    req1_ready = (state_q == IDLE) && req1_valid &&  grant_id;
  end

  // Next state: latch the winner, register the core output, then wait for the consumer
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          op_d    = grant_id ? req1_op : req0_op;
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          id_d    = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = core_y;
        err_d   = core_err;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; an asynchronous reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - randomized self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [7:0]  rsp_data;
  logic [15:0] done_cnt;
  logic        w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id, w_rsp_err;
  logic [7:0]  w_rsp_data;
  logic [1:0]  w_done_cnt;

  int vectors = 0;
  int miscompares = 0;
  int model_cnt = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .done_cnt(done_cnt)
  );

  logic_unit_arbiter #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data), .rsp_id(w_rsp_id),
    .rsp_err(w_rsp_err), .done_cnt(w_done_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = 8'hFF - a;
      3'd3: r = 8'hFF - (a & b);
      3'd4: r = 8'hFF - (a | b);
      3'd5: r = a ^ b;
      3'd6: r = 8'hFF - (a ^ b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_done_cnt_w", w_done_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    model_last = 1;
  endtask

  // One transaction: offer requests, check grant, latency, stall stability and completion
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [2:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [2:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                         input int stall);
    int g;
    logic [7:0] exp_data;
    logic       exp_err;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready  = 1'($urandom_range(0, 1));
    #1;
    if (!v0 && !v1) begin
      check("idle_ready0", req0_ready, 0);
      check("idle_ready1", req1_ready, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      return;
    end
    if (v0 && v1) g = 1 - model_last;
    else          g = v1 ? 1 : 0;
    check("grant_ready0", req0_ready, (g == 0) ? 1 : 0);
    check("grant_ready1", req1_ready, (g == 1) ? 1 : 0);
    exp_data = (g == 1) ? ref_op(o1, a1, b1) : ref_op(o0, a0, b0);
    exp_err  = ((g == 1) ? o1 : o0) == 3'd7;

    @(negedge clk);
    req0_valid = 1'($urandom_range(0, 1));
    req1_valid = 1'($urandom_range(0, 1));
    req0_a = 8'($urandom);
    req1_a = 8'($urandom);
    rsp_ready = 1'($urandom_range(0, 1));
    #1;
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_ready0", req0_ready, 0);
    check("exec_ready1", req1_ready, 0);

    @(negedge clk);
    rsp_ready = (stall == 0);
    #1;
    check("resp_valid", rsp_valid, 1);
    check("resp_data", rsp_data, exp_data);
    check("resp_id", rsp_id, g);
    check("resp_err", rsp_err, exp_err);
    check("resp_data_w", w_rsp_data, exp_data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      if (i == stall - 1) rsp_ready = 1'b1;
      #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, exp_data);
      check("stall_id", rsp_id, g);
      check("stall_ready0", req0_ready, 0);
      check("stall_ready1", req1_ready, 0);
      check("stall_cnt", done_cnt, model_cnt);
    end

    @(negedge clk);
    model_cnt  = model_cnt + 1;
    model_last = g;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("post_rsp_valid", rsp_valid, 0);
    check("done_cnt", done_cnt, model_cnt % 65536);
    check("done_cnt_w", w_done_cnt, model_cnt % 4);
  endtask

  initial begin
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_done_cnt", done_cnt, 0);
    check("reset_ready0", req0_ready, 0);
    check("reset_ready1", req1_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn(1, 0, 3'd0, 8'hF0, 8'h3C, 3'd0, 8'h00, 8'h00, 0);
    check("single_data_const", rsp_data, 8'h30);
    for (int op = 0; op < 8; op++)
      run_txn(0, 1, 3'd0, 8'h00, 8'h00, 3'(op), 8'hA5, 8'h0F, 0);

    apply_reset();
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 3'd5, 8'($urandom), 8'($urandom), 3'd1, 8'($urandom), 8'($urandom), 0);
    check("contention_cnt4", done_cnt, 4);

    run_txn(1, 0, 3'd6, 8'h12, 8'h34, 3'd0, 8'h00, 8'h00, 5);

    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h0F; req0_b = 8'hF0;
    req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_done_cnt", done_cnt, 0);
    check("midrst_done_cnt_w", w_done_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    model_last = 1;
    run_txn(1, 1, 3'd2, 8'h3C, 8'h00, 3'd3, 8'hFF, 8'hFF, 0);

    for (int n = 0; n < 200; n++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0 && !v0 && !v1) v1 = 1'b1;
      run_txn(v0, v1, 3'($urandom), 8'($urandom), 8'($urandom),
              3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
